// File: rtl/bicubic_src_stream_sched_pkg.sv
// Shared types and defaults for the bicubic source-stream scheduler.
// Default source geometry matches the reference BMP used by the upscaler.
package bicubic_src_stream_sched_pkg;

    localparam int SRC_IMG_WIDTH  = 64;
    localparam int SRC_IMG_HEIGHT = 48;
    localparam int PIX_DW         = 24;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic sof;
        logic eol;
        logic eof;
    } px_flags_t;

endpackage

// File: rtl/bicubic_src_stream_sched_credit_cnt.sv
// Saturating up/down line-credit counter with a sticky overflow flag.
// Reset loads the full credit count (upscaler line buffers all free).
module bicubic_credit_cnt #(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    output logic has_credit,
    output logic overflow
);

    localparam int W = $clog2(MAX + 1);
    localparam logic [W-1:0] MAXV = W'(MAX);

    logic [W-1:0] count_q, count_d;
    logic         ovf_q, ovf_d;

    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        // A release with every slot already free is a protocol error
        if (inc && count_q == MAXV) begin
            ovf_d = 1'b1;
        end
        if (inc && !dec && count_q != MAXV) begin
            count_d = count_q + W'(1);
        end else if (dec && !inc && count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= MAXV;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign has_credit = (count_q != '0);
    assign overflow   = ovf_q;

endmodule

// File: rtl/bicubic_src_stream_sched.sv
// Frame scheduler: admits one SRC_W x SRC_H frame per start, tags SOF/EOL/EOF,
// and gates each new line on an upscaler line-buffer credit.
module bicubic_src_stream_sched
    import bicubic_src_stream_sched_pkg::*;
#(
    parameter int SRC_W   = SRC_IMG_WIDTH,
    parameter int SRC_H   = SRC_IMG_HEIGHT,
    parameter int DW      = PIX_DW,
    parameter int CREDITS = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          m_sof,
    output logic          m_eol,
    output logic          m_eof,
    input  logic          line_release,
    output logic          busy,
    output logic          frame_done,
    output logic          credit_err
);

    localparam int CW = $clog2(SRC_W);
    localparam int RW = $clog2(SRC_H);
    localparam logic [CW-1:0] COL_LAST = CW'(SRC_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(SRC_H - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic            m_valid_q, m_valid_d;
    logic [DW-1:0]   m_data_q, m_data_d;
    px_flags_t       flags_q, flags_d;

    logic has_credit;
    logic accept;
    logic out_fire;
    logic col_first;
    logic col_last;
    logic row_last;

    assign col_first = (col_q == '0);
    assign col_last  = (col_q == COL_LAST);
    assign row_last  = (row_q == ROW_LAST);
    assign out_fire  = m_valid_q & m_ready;

    // Output slot free (or freeing) and, at a line start, a buffer line owned
    assign s_ready = (state_q == ST_RUN)
                   & (~m_valid_q | m_ready)
                   & (~col_first | has_credit);
    assign accept  = s_valid & s_ready;

    bicubic_credit_cnt #(
        .MAX (CREDITS)
    ) u_credit (
        .clk        (clk),
        .rst        (rst),
        .inc        (line_release),
        .dec        (accept & col_first),
        .has_credit (has_credit),
        .overflow   (credit_err)
    );

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        flags_d   = flags_q;

        if (accept) begin
            m_valid_d   = 1'b1;
            m_data_d    = s_data;
            flags_d.sof = col_first & (row_q == '0);
            flags_d.eol = col_last;
            flags_d.eof = col_last & row_last;
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end else if (out_fire) begin
            m_valid_d = 1'b0;
            flags_d   = '0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            ST_RUN: begin
                if (accept && col_last && row_last) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (out_fire) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            col_q     <= '0;
            row_q     <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            flags_q   <= '0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            flags_q   <= flags_d;
        end
    end

    assign m_valid    = m_valid_q;
    assign m_data     = m_data_q;
    assign m_sof      = flags_q.sof;
    assign m_eol      = flags_q.eol;
    assign m_eof      = flags_q.eof;
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_bicubic_src_stream_sched.sv
// Scoreboard bench for the source-stream scheduler (4x3 frame, 2 credits).
// Driver pushes expected pixels on accept; a negedge monitor pops and compares.
module tb_bicubic_src_stream_sched;

    localparam int W   = 4;
    localparam int H   = 3;
    localparam int C   = 2;
    localparam int NPX = W * H;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [23:0] s_data = '0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [23:0] m_data;
    logic        m_sof;
    logic        m_eol;
    logic        m_eof;
    logic        line_release = 1'b0;
    logic        busy;
    logic        frame_done;
    logic        credit_err;

    always #5 clk = ~clk;

    bicubic_src_stream_sched #(
        .SRC_W   (W),
        .SRC_H   (H),
        .DW      (24),
        .CREDITS (C)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_sof        (m_sof),
        .m_eol        (m_eol),
        .m_eof        (m_eof),
        .line_release (line_release),
        .busy         (busy),
        .frame_done   (frame_done),
        .credit_err   (credit_err)
    );

    int checks = 0;
    int errors = 0;
    logic [26:0] exp_q[$];

    int   px_sent = 0;
    int   px_target = 0;
    int   sv_pct = 100;
    int   mr_pct = 100;
    int   rel_timer = -1;
    int   rel_at_px = -1;
    int   done_cnt = 0;
    int   frame_d0 = 0;
    bit   auto_rel = 1'b0;
    bit   rel_req = 1'b0;
    bit   start_req = 1'b0;
    bit   start_in_done = 1'b0;
    logic [7:0] cur_tag = '0;

    bit          prev_stall = 1'b0;
    logic [23:0] prev_data = '0;

    function automatic logic [23:0] mk_data(logic [7:0] tag, int idx);
        logic [7:0] i8;
        i8 = 8'(idx);
        return {tag, i8, i8 ^ 8'hC3};
    endfunction

    function automatic logic [26:0] mk_exp(logic [7:0] tag, int idx);
        logic sof, eol, eof;
        sof = (idx == 0);
        eol = ((idx % W) == W - 1);
        eof = (idx == NPX - 1);
        return {mk_data(tag, idx), sof, eol, eof};
    endfunction

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Monitor: pops on every output handshake and polices stall stability
    always @(negedge clk) begin
        if (rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 32'(m_valid), 32'd1);
                chk("hold_data", 32'(m_data), 32'(prev_data));
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_px", 32'(exp_q.size()), 32'd1);
                end else begin
                    chk("px", 32'({m_data, m_sof, m_eol, m_eof}),
                        32'(exp_q.pop_front()));
                end
            end
            if (frame_done) done_cnt++;
            prev_stall <= m_valid && !m_ready;
            prev_data  <= m_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        start = start_req;
        start_req = 1'b0;
        m_ready = (int'($urandom_range(99)) < mr_pct);
        s_valid = (px_sent < px_target) && (int'($urandom_range(99)) < sv_pct);
        s_data  = mk_data(cur_tag, px_sent);
        line_release = rel_req || (rel_timer == 0)
                     || (rel_at_px >= 0 && px_sent == rel_at_px && s_valid);
        rel_req = 1'b0;
        if (rel_timer >= 0) rel_timer--;
        @(negedge clk);
        if (s_valid && s_ready) begin
            exp_q.push_back(mk_exp(cur_tag, px_sent));
            px_sent++;
        end
        if (auto_rel && m_valid && m_ready && m_eol) rel_timer = 2;
        if (start_in_done && m_valid && m_ready && m_eof) start_req = 1'b1;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic begin_frame(logic [7:0] tag);
        cur_tag   = tag;
        px_sent   = 0;
        px_target = NPX;
        start_req = 1'b1;
        frame_d0  = done_cnt;
    endtask

    task automatic run_to(int stop_px);
        for (int i = 0; i < 400; i++) begin
            tick();
            if (px_sent >= stop_px) break;
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 400; i++) begin
            tick();
            if (done_cnt != frame_d0) break;
        end
    endtask

    task automatic release_one();
        rel_req = 1'b1;
        tick();
        tick();
    endtask

    task automatic frame_end_checks(string name);
        chk({name, "_done_cnt"}, 32'(done_cnt - frame_d0), 32'd1);
        chk({name, "_px_sent"}, 32'(px_sent), 32'(NPX));
        chk({name, "_q_empty"}, 32'(exp_q.size()), 32'd0);
        chk({name, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_flags", 32'({m_sof, m_eol, m_eof, frame_done}), 32'd0);
        chk("rst_credit_err", 32'(credit_err), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // 1: streaming frame with timely line releases
        sv_pct = 100; mr_pct = 100; auto_rel = 1'b1;
        begin_frame(8'h11);
        wait_done();
        idle(8);
        frame_end_checks("t1");
        chk("t1_credit_err", 32'(credit_err), 32'd0);

        // 2: no releases -> two lines pass, third line stalls on credit
        auto_rel = 1'b0;
        begin_frame(8'h22);
        run_to(8);
        idle(6);
        chk("t2_stall_px", 32'(px_sent), 32'd8);
        chk("t2_s_ready", 32'(s_ready), 32'd0);
        chk("t2_busy", 32'(busy), 32'd1);
        rel_req = 1'b1;
        wait_done();
        idle(4);
        frame_end_checks("t2");
        release_one();
        release_one();
        chk("t2_credit_err", 32'(credit_err), 32'd0);

        // 3: random source and sink backpressure
        sv_pct = 50; mr_pct = 50; auto_rel = 1'b1;
        for (int f = 0; f < 2; f++) begin
            begin_frame(8'h33 + 8'(f));
            wait_done();
            idle(8);
            frame_end_checks("t3");
        end

        // 4: release coincides with consume at (1,0); then overflow
        sv_pct = 100; mr_pct = 100; auto_rel = 1'b0; rel_timer = -1;
        rel_at_px = 4;
        begin_frame(8'h44);
        wait_done();
        idle(4);
        rel_at_px = -1;
        frame_end_checks("t4");
        release_one();
        chk("t4_err_after_1", 32'(credit_err), 32'd0);
        release_one();
        chk("t4_err_after_2", 32'(credit_err), 32'd0);
        release_one();
        chk("t4_err_set", 32'(credit_err), 32'd1);
        idle(5);
        chk("t4_err_sticky", 32'(credit_err), 32'd1);

        // 5: reset while an output pixel is stalled
        begin_frame(8'h55);
        run_to(6);
        mr_pct = 0;
        idle(3);
        chk("t5_pre_stall", 32'(m_valid), 32'd1);
        px_target = 0;
        @(posedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        rel_timer = -1;
        @(posedge clk);
        @(negedge clk);
        chk("t5_m_valid", 32'(m_valid), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_s_ready", 32'(s_ready), 32'd0);
        chk("t5_credit_err", 32'(credit_err), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(2);
        chk("t5_no_done", 32'(done_cnt - frame_d0), 32'd0);
        mr_pct = 100;
        begin_frame(8'h66);
        run_to(8);
        idle(6);
        chk("t5_credits_restored", 32'(px_sent), 32'd8);
        rel_req = 1'b1;
        wait_done();
        idle(4);
        frame_end_checks("t5");
        release_one();
        release_one();

        // 6: start during RUN and during DONE is ignored
        auto_rel = 1'b1;
        start_in_done = 1'b1;
        begin_frame(8'h77);
        run_to(5);
        start_req = 1'b1;
        wait_done();
        start_in_done = 1'b0;
        idle(8);
        frame_end_checks("t6a");
        begin_frame(8'h77);
        wait_done();
        idle(8);
        frame_end_checks("t6b");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
